// File: rtl/consul_pkg.sv
// Shared definitions for the Consul 260 keyboard receiver: regs_in bit map,
// special key codes, receiver FSM states and the code-to-ASCII decode.
package consul_pkg;

   // regs_in bit positions ([7:0] carry the key code)
   localparam int unsigned RI_NEED_NL     = 8;
   localparam int unsigned RI_BLOCK_PRINT = 9;
   localparam int unsigned RI_IS_MOVING   = 10;
   localparam int unsigned RI_HIGH_REG    = 11;
   localparam int unsigned RI_CO_ACQ      = 12;
   localparam int unsigned RI_RED_PRINT   = 13;
   localparam int unsigned RI_LOW_REG     = 14;
   localparam int unsigned RI_CIN_READY   = 15;

   // special codes, compared against in[6:0]
   localparam logic [7:0] SP_CR    = 8'h0D;
   localparam logic [7:0] SP_SPACE = 8'h2E;
   localparam logic [7:0] SP_ZERO  = 8'h3F;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_CAPTURE,
      S_RELEASE
   } kb_state_t;

   function automatic logic kb_is_special(input logic [6:0] code);
      return ({1'b0, code} == SP_CR) || ({1'b0, code} == SP_SPACE) ||
             ({1'b0, code} == SP_ZERO);
   endfunction

   // The space and zero keys carry even parity on the wire, so special codes
   // are accepted on their own; everything else needs odd parity on [6:0].
   function automatic logic kb_code_valid(input logic [7:0] code);
      return code[7] && ((^code[6:0]) || kb_is_special(code[6:0]));
   endfunction

   function automatic logic [7:0] kb_decode(input logic [6:0] code,
                                            input logic       high_reg,
                                            input logic       low_reg);
      logic [2:0] hi;
      hi = code[6:4];
      if ({1'b0, code} == SP_CR)         return 8'h0D;
      else if ({1'b0, code} == SP_SPACE) return 8'h20;
      else if ({1'b0, code} == SP_ZERO)  return 8'h30;
      if (high_reg && hi == 3'd3)            hi = 3'd2;
      else if (low_reg && hi == 3'd4)        hi = 3'd6;
      else if (low_reg && hi == 3'd5)        hi = 3'd7;
      return {1'b0, hi, code[3:0]};
   endfunction

endpackage

// File: rtl/consul_kb_fifo.sv
// First-word-fall-through FIFO; head word is forced to zero while empty.
module kb_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             vld,
   output logic             full
);

   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CNTW-1:0]  count, count_next;
   logic             do_push, do_pop;

   assign vld      = (count != '0);
   assign do_pop   = pop && vld;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = vld ? mem[rd_ptr] : '0;

   // occupancy after this cycle's push/pop
   always_comb begin
      count_next = count;
      if (do_push && !do_pop)      count_next = count + 1'b1;
      else if (do_pop && !do_push) count_next = count - 1'b1;
   end

   // pointers, occupancy and registered full flag
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next == CNTW'(DEPTH));
      end
   end

   // storage array, written on accepted pushes
   always_ff @(posedge Clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/consul_kb.sv
// Consul 260 keyboard receiver: debounces key strobes, validates and decodes
// the key code to ASCII and buffers characters for a ready/valid consumer.
module consul_kb
   import consul_pkg::*;
#(
   parameter int unsigned DEBOUNCE   = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [15:0] regs_in,
   output logic [7:0]  kb_data_o,
   output logic        kb_data_vld,
   input  logic        kb_data_rdy,
   output logic        kb_block_o,
   output logic        parity_err_o,
   output logic        overflow_o
);

   localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic [15:0]   regs_q;
   kb_state_t     state;
   logic [CW-1:0] cnt;
   logic [7:0]    code_l;
   logic          high_l, low_l;
   logic          cin, same_code, code_ok, pop, push;
   logic [7:0]    push_data;

   assign cin       = regs_q[RI_CIN_READY];
   assign same_code = (regs_q[7:0] == code_l);
   assign code_ok   = kb_code_valid(code_l);
   assign pop       = kb_data_vld && kb_data_rdy;
   assign push      = (state == S_CAPTURE) && code_ok && (!kb_block_o || pop);
   assign push_data = kb_decode(code_l[6:0], high_l, low_l);

   // single input register; nothing below looks at raw regs_in
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) regs_q <= '0;
      else     regs_q <= regs_in;
   end

   // key strobe FSM with registered error/overflow pulses
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         code_l       <= '0;
         high_l       <= 1'b0;
         low_l        <= 1'b0;
         parity_err_o <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         parity_err_o <= 1'b0;
         overflow_o   <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (cin) begin
                  code_l <= regs_q[7:0];
                  high_l <= regs_q[RI_HIGH_REG];
                  low_l  <= regs_q[RI_LOW_REG];
                  state  <= S_DEBOUNCE;
               end
            end
            S_DEBOUNCE: begin
               if (!cin || !same_code) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else if (cnt == CW'(DEBOUNCE - 1)) begin
                  state <= S_CAPTURE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               parity_err_o <= !code_ok;
               overflow_o   <= code_ok && kb_block_o && !pop;
               state        <= S_RELEASE;
               cnt          <= '0;
            end
            S_RELEASE: begin
               if (cin) begin
                  cnt <= '0;
               end else if (cnt == CW'(DEBOUNCE - 1)) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   kb_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Rst       (Rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (kb_data_o),
      .vld       (kb_data_vld),
      .full      (kb_block_o)
   );

endmodule

// File: tb/tb_consul_kb.sv
// Bench for consul_kb: table of single keys plus sequences for latency,
// glitches, release bounce, overflow and reset during debounce.
module tb_consul_kb;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [15:0] regs_in = '0;
   logic [7:0]  kb_data_o;
   logic        kb_data_vld;
   logic        kb_data_rdy = 1'b0;
   logic        kb_block_o;
   logic        parity_err_o;
   logic        overflow_o;

   int compared   = 0;
   int mismatched = 0;
   int par_cnt    = 0;
   int ovf_cnt    = 0;
   int pop_cnt    = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic [7:0] code;
      logic       hi;
      logic       lo;
      logic       ok;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [14];

   consul_kb #(.DEBOUNCE(4), .FIFO_DEPTH(4)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .regs_in      (regs_in),
      .kb_data_o    (kb_data_o),
      .kb_data_vld  (kb_data_vld),
      .kb_data_rdy  (kb_data_rdy),
      .kb_block_o   (kb_block_o),
      .parity_err_o (parity_err_o),
      .overflow_o   (overflow_o)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard side: count pulses and compare every handshake with the queue
   always @(negedge Clk) begin
      if (parity_err_o) par_cnt++;
      if (overflow_o)   ovf_cnt++;
      if (kb_data_vld && kb_data_rdy) begin
         pop_cnt++;
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected char: got %0h, expected none", kb_data_o);
         end else begin
            chk("rx char", {24'h0, kb_data_o}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // ignored status lines get random values to show they have no effect
   task automatic set_key(input logic [7:0] code, input logic hi, input logic lo,
                          input logic cin);
      logic [15:0] r;
      r       = 16'($urandom);
      r[7:0]  = code;
      r[11]   = hi;
      r[14]   = lo;
      r[15]   = cin;
      regs_in = r;
   endtask

   task automatic press(input logic [7:0] code, input logic hi, input logic lo,
                        input int hold, input int rel);
      set_key(code, hi, lo, 1'b1);
      repeat (hold) tick();
      set_key(code, hi, lo, 1'b0);
      repeat (rel) tick();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " data"},  {24'h0, kb_data_o}, 32'h0);
      chk({tag, " vld"},   {31'h0, kb_data_vld}, 32'h0);
      chk({tag, " block"}, {31'h0, kb_block_o}, 32'h0);
      chk({tag, " perr"},  {31'h0, parity_err_o}, 32'h0);
      chk({tag, " ovf"},   {31'h0, overflow_o}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, e0, o0;
      vecs[0]  = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'h43};
      vecs[1]  = '{8'hBF, 1'b0, 1'b0, 1'b1, 8'h30};
      vecs[2]  = '{8'hAE, 1'b0, 1'b0, 1'b1, 8'h20};
      vecs[3]  = '{8'hB1, 1'b1, 1'b0, 1'b1, 8'h21};
      vecs[4]  = '{8'hB1, 1'b0, 1'b0, 1'b1, 8'h31};
      vecs[5]  = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'h63};
      vecs[6]  = '{8'h8D, 1'b0, 1'b0, 1'b1, 8'h0D};
      vecs[7]  = '{8'hD1, 1'b0, 1'b1, 1'b1, 8'h71};
      vecs[8]  = '{8'hE7, 1'b1, 1'b1, 1'b1, 8'h67};
      vecs[9]  = '{8'hAE, 1'b1, 1'b1, 1'b1, 8'h20};
      vecs[10] = '{8'hB1, 1'b0, 1'b1, 1'b1, 8'h31};
      vecs[11] = '{8'hC1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[12] = '{8'h43, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[13] = '{8'hD5, 1'b0, 1'b0, 1'b0, 8'h00};

      // reset state
      repeat (3) tick();
      chk_idle_outputs("reset");
      Rst = 1'b0;
      tick();

      // basic receive with latency check
      exp_q.push_back(8'h43);
      p0 = pop_cnt;
      set_key(8'hC3, 1'b0, 1'b0, 1'b1);
      repeat (6) tick();
      chk("latency vld early", {31'h0, kb_data_vld}, 32'h0);
      tick();
      chk("latency vld", {31'h0, kb_data_vld}, 32'h1);
      chk("latency data", {24'h0, kb_data_o}, 32'h43);
      repeat (3) tick();
      kb_data_rdy = 1'b1;
      set_key(8'hC3, 1'b0, 1'b0, 1'b0);
      repeat (8) tick();
      chk("basic pops", pop_cnt - p0, 1);
      chk("basic vld after pop", {31'h0, kb_data_vld}, 32'h0);

      // table of single keys
      for (int i = 0; i < 14; i++) begin
         p0 = pop_cnt;
         e0 = par_cnt;
         if (vecs[i].ok) exp_q.push_back(vecs[i].exp);
         press(vecs[i].code, vecs[i].hi, vecs[i].lo, 8, 8);
         chk($sformatf("vec%0d pops", i), pop_cnt - p0, vecs[i].ok ? 1 : 0);
         chk($sformatf("vec%0d perr", i), par_cnt - e0, vecs[i].ok ? 0 : 1);
         chk($sformatf("vec%0d q", i), exp_q.size(), 0);
      end

      // short glitch on cin_ready
      p0 = pop_cnt;
      press(8'hC3, 1'b0, 1'b0, 2, 10);
      chk("glitch pops", pop_cnt - p0, 0);

      // release bounce: the long high phase must not become a second key
      p0 = pop_cnt;
      exp_q.push_back(8'h45);
      set_key(8'hC5, 1'b0, 1'b0, 1'b1); repeat (8) tick();
      set_key(8'hC5, 1'b0, 1'b0, 1'b0); repeat (3) tick();
      set_key(8'hC5, 1'b0, 1'b0, 1'b1); tick();
      set_key(8'hC5, 1'b0, 1'b0, 1'b0); repeat (3) tick();
      set_key(8'hC5, 1'b0, 1'b0, 1'b1); repeat (5) tick();
      set_key(8'hC5, 1'b0, 1'b0, 1'b0); repeat (10) tick();
      chk("bounce pops", pop_cnt - p0, 1);

      // overflow with consumer stalled
      kb_data_rdy = 1'b0;
      p0 = pop_cnt;
      exp_q.push_back(8'h43); press(8'hC3, 1'b0, 1'b0, 8, 8);
      exp_q.push_back(8'h45); press(8'hC5, 1'b0, 1'b0, 8, 8);
      exp_q.push_back(8'h46); press(8'hC6, 1'b0, 1'b0, 8, 8);
      chk("block after 3", {31'h0, kb_block_o}, 32'h0);
      exp_q.push_back(8'h49); press(8'hC9, 1'b0, 1'b0, 8, 8);
      chk("block after 4", {31'h0, kb_block_o}, 32'h1);
      o0 = ovf_cnt;
      e0 = par_cnt;
      press(8'hCA, 1'b0, 1'b0, 8, 8);
      chk("overflow pulses", ovf_cnt - o0, 1);
      chk("overflow perr", par_cnt - e0, 0);
      chk("overflow head", {24'h0, kb_data_o}, 32'h43);
      kb_data_rdy = 1'b1;
      repeat (8) tick();
      kb_data_rdy = 1'b0;
      chk("drain pops", pop_cnt - p0, 4);
      chk("drain block", {31'h0, kb_block_o}, 32'h0);
      chk("drain q", exp_q.size(), 0);

      // reset in the middle of debounce, key still held afterwards
      kb_data_rdy = 1'b1;
      p0 = pop_cnt;
      set_key(8'hC3, 1'b0, 1'b0, 1'b1);
      repeat (3) tick();
      Rst = 1'b1;
      #1;
      chk_idle_outputs("mid reset");
      tick();
      Rst = 1'b0;
      exp_q.push_back(8'h43);
      repeat (10) tick();
      set_key(8'hC3, 1'b0, 1'b0, 1'b0);
      repeat (8) tick();
      chk("reset key pops", pop_cnt - p0, 1);
      chk("final q", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/consul_kb.md
CONSUL_KB -- requirements
Module: consul_kb

Interface
REQ-001 Parameter DEBOUNCE, default 4: number of consecutive stable cycles required on key press and on key release.
REQ-002 Parameter FIFO_DEPTH, default 4: number of received characters buffered; must be a power of two.
REQ-003 Port Clk, input, 1: the single clock.
REQ-004 Port Rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port regs_in, input, 16: raw Consul 260 input lines.
- [7:0] in code
- [8] need_nl, [9] block_print, [10] is_moving
- [11] high_reg, [12] coAcq, [13] red_print
- [14] low_reg, [15] cin_ready
REQ-006 Port kb_data_o, output, 8: ASCII character at the FIFO head; bit 7 is always 0.
REQ-007 Port kb_data_vld, output, 1: FIFO not empty.
REQ-008 Port kb_data_rdy, input, 1: consumer accepts; a pop occurs on kb_data_vld & kb_data_rdy.
REQ-009 Port kb_block_o, output, 1: drives the typewriter set_kb_block line; high while the FIFO is full.
REQ-010 Port parity_err_o, output, 1: one-cycle pulse when a captured code is invalid.
REQ-011 Port overflow_o, output, 1: one-cycle pulse when a valid code is dropped because the FIFO is full.

Function
REQ-012 regs_in SHALL be registered once; all logic uses only the registered copy.
REQ-013 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, CAPTURE and RELEASE.
REQ-014 IDLE: on cin_ready=1, latch in[7:0], high_reg and low_reg, then go to DEBOUNCE.
REQ-015 DEBOUNCE: stay exactly DEBOUNCE cycles, then go to CAPTURE; if cin_ready drops or in[7:0] differs from the latched value, return to IDLE with no output.
REQ-016 CAPTURE (1 cycle): the code is valid iff in[7]=1 and in[6:0] has odd parity.
- valid: decode and push, or pulse overflow_o if no space
- invalid: pulse parity_err_o
- then go to RELEASE
REQ-017 RELEASE: go to IDLE after DEBOUNCE consecutive cycles of cin_ready=0; any cin_ready=1 restarts the count.
REQ-018 Decode: special codes are checked first.
- 0x0D -> 0x0D
- 0x2E -> 0x20
- 0x3F -> 0x30
REQ-019 Decode, otherwise: the low nibble passes through, and the high nibble maps as follows.
- 3 -> 2 if high_reg, else unchanged
- 4 -> 6 and 5 -> 7 if low_reg, else unchanged
- all other nibbles unchanged
REQ-020 Latency: kb_data_vld SHALL rise after DEBOUNCE+2 Clk edges following the edge that first samples cin_ready=1 into the register, when the FIFO was empty.
REQ-021 The FIFO is first-word-fall-through.
- a push when full is allowed only if a pop occurs in the same cycle
- simultaneous push and pop keeps occupancy unchanged
- pointers wrap modulo FIFO_DEPTH
REQ-022 kb_block_o SHALL be registered and equal to (occupancy == FIFO_DEPTH).
REQ-023 need_nl, block_print, is_moving, coAcq and red_print SHALL be ignored.

Reset
REQ-024 When Rst is asserted:
- FSM -> IDLE; FIFO emptied; counters cleared
- kb_data_o=0x00; kb_data_vld, kb_block_o, parity_err_o, overflow_o = 0
REQ-025 A reset asserted mid-debounce or mid-release SHALL discard the key with no output; a key still held after reset is received normally.

Structure
REQ-026 Shared package consul_pkg SHALL hold:
- regs_in bit-index constants
- special-code constants (0x0D, 0x2E, 0x3F)
- the FSM state enum
- the decode function
REQ-027 The FIFO SHALL be a sub-module named kb_fifo, parameterised by width and depth.

Verification
REQ-028 Basic receive: in=0xC3, high_reg=0, low_reg=0, cin_ready held 10 cycles, DEBOUNCE=4 -> kb_data_o=0x43 with vld after 6 edges; rdy=1 pops; exactly one character.
REQ-029 Specials and register shift, all with low_reg=0:
- 0xBF -> 0x30
- 0xAE -> 0x20
- 0xB1 with high_reg=1 -> 0x21
- 0xB1 with high_reg=0 -> 0x31
- 0xC3 with low_reg=1 -> 0x63
REQ-030 Invalid code: in=0xC1 (even parity) held -> one parity_err_o pulse; kb_data_vld stays 0.
REQ-031 Glitches: cin_ready high 2 cycles -> no output. Key release bouncing 1-0-1-0 -> the RELEASE count restarts and only one character is produced.
REQ-032 Overflow: rdy=0, five valid keys 0xC3,0xC5,0xC6,0xC9,0xCA:
- kb_block_o=1 after the fourth push
- fifth key -> one overflow_o pulse
- draining yields 0x43,0x45,0x46,0x49 in order, then kb_block_o=0
REQ-033 Reset mid-debounce: Rst pulsed during DEBOUNCE -> all outputs 0; the held key is received once after reset.
